// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction classes, opcodes and immediate limits.
package riscv_pkg;

    typedef enum logic [2:0] {
        CLS_LW    = 3'd0,
        CLS_SW    = 3'd1,
        CLS_RTYPE = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_IALU  = 3'd4,
        CLS_JAL   = 3'd5
    } instr_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int IMM_I_MIN = -32'sd2048;
    localparam int IMM_I_MAX = 32'sd2047;
    localparam int IMM_B_MIN = -32'sd4096;
    localparam int IMM_B_MAX = 32'sd4094;
    localparam int IMM_J_MIN = -32'sd1048576;
    localparam int IMM_J_MAX = 32'sd1048574;

    function automatic logic imm_ok(input logic signed [20:0] v_imm, input int lo,
                                    input int hi, input logic need_even);
        int v;
        v = int'(v_imm);
        return (v >= lo) && (v <= hi) && !(need_even && v_imm[0]);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit word for a bundle and flags bad class/immediate.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  in_class,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic [31:0] o_word,
    output logic        o_err
);

    // Per-class field packing and immediate range check
    always_comb begin
        o_word = 32'h0000_0000;
        o_err  = 1'b0;
        case (instr_class_e'(in_class))
            CLS_LW: begin
                o_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
                o_err  = !imm_ok($signed(imm), IMM_I_MIN, IMM_I_MAX, 1'b0);
            end
            CLS_SW: begin
                o_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
                o_err  = !imm_ok($signed(imm), IMM_I_MIN, IMM_I_MAX, 1'b0);
            end
            CLS_RTYPE: begin
                o_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
                o_err  = 1'b0;
            end
            CLS_BEQ: begin
                o_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
                o_err  = !imm_ok($signed(imm), IMM_B_MIN, IMM_B_MAX, 1'b1);
            end
            CLS_IALU: begin
                o_word = {imm[11:0], rs1, funct3, rd, OP_IALU};
                o_err  = !imm_ok($signed(imm), IMM_I_MIN, IMM_I_MAX, 1'b0);
            end
            CLS_JAL: begin
                o_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                o_err  = !imm_ok($signed(imm), IMM_J_MIN, IMM_J_MAX, 1'b1);
            end
            default: begin
                o_word = 32'h0000_0000;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load session controller: accepts field bundles, encodes them and writes
// one instruction word per accepted bundle to sequential instruction-memory addresses.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_class,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [15:0] r_count;
    logic        r_err;
    logic        r_last;
    logic        r_in_ready;
    logic        r_done;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [1:0]  w_next_state;
    logic [31:0] w_word;
    logic        w_pack_err;
    logic        w_fire;

    instr_pack u_pack (
        .in_class (in_class),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .o_word   (w_word),
        .o_err    (w_pack_err)
    );

    assign w_fire = in_valid & r_in_ready;

    // Next-state logic; start from any state (re)opens a session
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_ACCEPT;
        end else begin
            case (r_state)
                S_IDLE:   w_next_state = S_IDLE;
                S_ACCEPT: w_next_state = w_fire ? S_WRITE : S_ACCEPT;
                S_WRITE:  w_next_state = r_last ? S_DONE : S_ACCEPT;
                S_DONE:   w_next_state = S_DONE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // State, write-port and session bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'h0000_0000;
            r_count     <= 16'h0000;
            r_err       <= 1'b0;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == S_ACCEPT);
            r_done     <= (w_next_state == S_DONE);
            r_mem_we   <= 1'b0;
            if (start) begin
                r_addr  <= base_addr;
                r_count <= 16'h0000;
                r_err   <= 1'b0;
                r_last  <= 1'b0;
            end else if ((r_state == S_ACCEPT) && w_fire) begin
                r_last <= in_last;
                if (w_pack_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= w_word;
                end
            end else if ((r_state == S_WRITE) && r_mem_we) begin
                // A rejected word never raised mem_we, so it consumes no address
                r_addr <= r_addr + 32'd4;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_class;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [20:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic [15:0] count;

    int total;
    int bad;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_class  (in_class),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one bundle and returns #1 after the handshake edge (the write cycle)
    task automatic drive_word(input logic [2:0] cls, input logic [4:0] v_rd, input logic [4:0] v_rs1,
                              input logic [4:0] v_rs2, input logic [2:0] f3, input logic f7,
                              input logic [20:0] v_imm, input logic last);
        int n;
        in_class = cls; rd = v_rd; rs1 = v_rs1; rs2 = v_rs2;
        funct3 = f3; funct7b5 = f7; imm = v_imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; in_last = 1'b0;
        in_class = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7b5 = 1'b0; imm = 21'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({in_ready, mem_we, done, err} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags got=%b required=0000", {in_ready, mem_we, done, err}); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++;
            $display("FAIL reset_bus addr=%h data=%h required=0", mem_addr, mem_wdata); end
        total++; if (count !== 16'h0) begin bad++;
            $display("FAIL reset_count got=%h required=0", count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++;
            $display("FAIL idle_ready got=%b required=0", in_ready); end
    endtask

    task automatic test_addi();
        do_start(32'h0000_0100);
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0100, 32'h0050_0093}) begin bad++;
            $display("FAIL addi_write we=%b addr=%h data=%h required 1/00000100/00500093", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        total++; if (mem_we !== 1'b0 || count !== 16'd1) begin bad++;
            $display("FAIL addi_after we=%b count=%0d required 0/1", mem_we, count); end
        total++; if (mem_addr !== 32'h0000_0100 || mem_wdata !== 32'h0050_0093) begin bad++;
            $display("FAIL addi_hold addr=%h data=%h required 00000100/00500093", mem_addr, mem_wdata); end
    endtask

    task automatic test_load_store();
        do_start(32'h0000_0100);
        total++; if (count !== 16'd0) begin bad++;
            $display("FAIL restart_count got=%0d required=0", count); end
        drive_word(3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0100, 32'h0080_A103}) begin bad++;
            $display("FAIL lw_write we=%b addr=%h data=%h required 1/00000100/0080a103", mem_we, mem_addr, mem_wdata); end
        drive_word(3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd4, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0104, 32'h0020_A223}) begin bad++;
            $display("FAIL sw_write we=%b addr=%h data=%h required 1/00000104/0020a223", mem_we, mem_addr, mem_wdata); end
    endtask

    task automatic test_back_to_back();
        do_start(32'h0000_0200);
        drive_word(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0200, 32'h0020_81B3}) begin bad++;
            $display("FAIL add_write we=%b addr=%h data=%h required 1/00000200/002081b3", mem_we, mem_addr, mem_wdata); end
        drive_word(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0204, 32'h4020_81B3}) begin bad++;
            $display("FAIL sub_write we=%b addr=%h data=%h required 1/00000204/402081b3", mem_we, mem_addr, mem_wdata); end
        drive_word(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1F_FFFC, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0208, 32'hFE20_8EE3}) begin bad++;
            $display("FAIL beq_write we=%b addr=%h data=%h required 1/00000208/fe208ee3", mem_we, mem_addr, mem_wdata); end
        drive_word(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_020C, 32'h0080_00EF}) begin bad++;
            $display("FAIL jal_write we=%b addr=%h data=%h required 1/0000020c/008000ef", mem_we, mem_addr, mem_wdata); end
        total++; if (done !== 1'b0) begin bad++;
            $display("FAIL done_early got=%b required=0", done); end
        @(posedge clk); #1;
        total++; if ({done, in_ready, mem_we} !== 3'b100 || count !== 16'd4) begin bad++;
            $display("FAIL session_done done/ready/we=%b count=%0d required 100/4", {done, in_ready, mem_we}, count); end
    endtask

    task automatic test_errors();
        do_start(32'h0000_0300);
        drive_word(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3, 1'b0);
        total++; if (mem_we !== 1'b0 || err !== 1'b1) begin bad++;
            $display("FAIL beq_odd we=%b err=%b required 0/1", mem_we, err); end
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048, 1'b0);
        total++; if (mem_we !== 1'b0) begin bad++;
            $display("FAIL addi_range we=%b required=0", mem_we); end
        drive_word(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0, 1'b0);
        total++; if (mem_we !== 1'b0 || count !== 16'd0) begin bad++;
            $display("FAIL bad_class we=%b count=%0d required 0/0", mem_we, count); end
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0300, 32'h0050_0093}) begin bad++;
            $display("FAIL after_err we=%b addr=%h data=%h required 1/00000300/00500093", mem_we, mem_addr, mem_wdata); end
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1F_F800, 1'b1);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0304, 32'h8000_0093}) begin bad++;
            $display("FAIL addi_min we=%b addr=%h data=%h required 1/00000304/80000093", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        total++; if (err !== 1'b1 || count !== 16'd2 || done !== 1'b1) begin bad++;
            $display("FAIL err_sticky err=%b count=%0d done=%b required 1/2/1", err, count, done); end
    endtask

    task automatic test_wrap();
        do_start(32'hFFFF_FFFC);
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0);
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin bad++;
            $display("FAIL wrap_first we=%b addr=%h required 1/fffffffc", mem_we, mem_addr); end
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b1);
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0000) begin bad++;
            $display("FAIL wrap_second we=%b addr=%h required 1/00000000", mem_we, mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_start(32'h0000_0400);
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0);
        reset_n = 1'b0;
        #1;
        total++; if ({in_ready, mem_we, done, err} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || count !== 16'h0) begin bad++;
            $display("FAIL midreset flags=%b addr=%h data=%h count=%0d required 0000/0/0/0", {in_ready, mem_we, done, err}, mem_addr, mem_wdata, count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (mem_we !== 1'b0 || count !== 16'h0) begin bad++;
            $display("FAIL midreset_nowrite we=%b count=%0d required 0/0", mem_we, count); end
        do_start(32'h0000_0500);
        drive_word(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b1);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0500, 32'h0050_0093}) begin bad++;
            $display("FAIL fresh_session we=%b addr=%h data=%h required 1/00000500/00500093", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        total++; if (count !== 16'd1 || done !== 1'b1) begin bad++;
            $display("FAIL fresh_done count=%0d done=%b required 1/1", count, done); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_addi();
        test_load_store();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that begins a program-load session.
REQ-004 SHALL have port base_addr, input, 32, first write address, sampled on start.
REQ-005 SHALL have port in_valid, input, 1, instruction-field bundle valid.
REQ-006 SHALL have port in_ready, output, 1, bundle accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_last, input, 1, marks the final bundle of the session.
REQ-008 SHALL have port in_class, input, 3, instruction class: 0 LW, 1 SW, 2 R-type, 3 BEQ, 4 I-ALU, 5 JAL; 6-7 invalid.
REQ-009 SHALL have ports rd, rs1 and rs2, input, 5 each, register indices.
REQ-010 SHALL have ports funct3 (input, 3) and funct7b5 (input, 1), used for R-type and I-ALU only.
REQ-011 SHALL have port imm, input, 21, signed immediate or byte offset.
REQ-012 SHALL have ports mem_we (output, 1), mem_addr (output, 32) and mem_wdata (output, 32), the instruction-memory write port.
REQ-013 SHALL have ports done (output, 1), err (output, 1, sticky) and count (output, 16, words written).

Function
REQ-014 SHALL implement FSM states IDLE, ACCEPT, WRITE and DONE.
REQ-015 SHALL follow these transitions:
- IDLE -start-> ACCEPT.
- ACCEPT -handshake-> WRITE.
- WRITE -in_last captured-> DONE; otherwise WRITE -> ACCEPT.
- DONE -start-> ACCEPT.
REQ-016 SHALL on start load the address register with base_addr and clear count and err; a start in ACCEPT or WRITE SHALL abort the current word and restart.
REQ-017 SHALL assert in_ready only in ACCEPT, giving a maximum throughput of one word per 2 cycles.
REQ-018 SHALL, when a handshake occurs in cycle N, register the encoded word and assert mem_we for exactly cycle N+1 with mem_addr equal to the current address.
REQ-019 SHALL, after each write, increment the address by 4 (mod 2^32, wrapping) and increment count (saturating at 0xFFFF).
REQ-020 SHALL encode LW as {imm[11:0], rs1, 010, rd, 0000011}.
REQ-021 SHALL encode SW as {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
REQ-022 SHALL encode R-type as {0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011}.
REQ-023 SHALL encode I-ALU as {imm[11:0], rs1, funct3, rd, 0010011}.
REQ-024 SHALL encode BEQ as {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
REQ-025 SHALL encode JAL as {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-026 SHALL enforce these immediate ranges, with any violation classed as an error:
- LW, SW and I-ALU: -2048..2047.
- BEQ: -4096..4094, even.
- JAL: full 21-bit range, even.
REQ-027 SHALL, on an invalid class or immediate error, set err, suppress mem_we, and leave the address and count unchanged; the FSM still honours in_last.
REQ-028 SHALL assert done only in DONE.
REQ-029 SHALL drive mem_wdata and mem_addr to hold their last values whenever mem_we is low.

Reset
REQ-030 SHALL on reset_n low immediately force: FSM to IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, err 0, done 0.
REQ-031 SHALL, if reset_n is asserted mid-session, perform no write, with the session lost.

Structure
REQ-032 SHALL place the class enum, the six opcode constants and the immediate range limits in a shared package riscv_pkg.
REQ-033 SHALL implement field packing and range checking in a combinational sub-module instr_pack, with the FSM, counters and registers in instr_encoder.

Verification
REQ-034 SHALL cover: start with base_addr=0x100, then addi x1,x0,5 (class 4, funct3 0, imm 5) -> mem_we at 0x100 with 0x00500093, count 1.
REQ-035 SHALL cover: lw x2,8(x1), then sw x2,4(x1) -> 0x0080A103 at 0x100 and 0x0020A223 at 0x104.
REQ-036 SHALL cover: add x3,x1,x2, then sub (funct7b5=1), then beq x1,x2,-4, then jal x1,8 with in_last -> 0x002081B3, 0x402081B3, 0xFE208EE3, 0x008000EF, then done high and count 4.
REQ-037 SHALL cover: beq imm=3, then addi imm=2048, then class 7 -> err high, no mem_we, count unchanged; the next valid word still lands at the next sequential address.
REQ-038 SHALL cover: base_addr=0xFFFFFFFC with two words -> writes at 0xFFFFFFFC, then 0x00000000.
REQ-039 SHALL cover: reset_n dropped in WRITE, then start -> no write for the aborted word, all outputs at their reset values, and a fresh session from base_addr.
